// File: rtl/stop_watch_lap_mem_pkg.sv
// Shared types for the stopwatch mode: FSM states, BCD time record,
// button bit positions and display view selection.
package stop_watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STOP   = 2'd2,
    ST_RECALL = 2'd3
  } state_t;

  localparam int TIME_W = 24;

  // mm:ss.cc, one BCD digit per nibble, most significant digit first
  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
    logic [3:0] csec10;
    logic [3:0] csec1;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = 24'h595999;

  localparam int BTN_START  = 0;
  localparam int BTN_LAP    = 1;
  localparam int BTN_RECALL = 2;
  localparam int BTN_VIEW   = 3;

  localparam logic VIEW_SEC = 1'b0;  // ss.cc
  localparam logic VIEW_MIN = 1'b1;  // mm:ss

  // Pick the four digits shown for the selected view window
  function automatic logic [15:0] view_digits(input bcd_time_t t, input logic view);
    if (view == VIEW_SEC) return {t.sec10, t.sec1, t.csec10, t.csec1};
    return {t.min10, t.min1, t.sec10, t.sec1};
  endfunction

endpackage

// File: rtl/stop_watch_lap_mem_if.sv
// Button/display bundle between the button edge detectors, the stopwatch
// and the display mux. btn_pedge bits are single-cycle pulses with no
// backpressure: the stopwatch acts on a bit in the exact cycle it is high,
// and every output is valid every cycle (no valid/ready pair is needed).
interface stop_watch_lap_mem_if #(
  parameter int LAP_DEPTH = 4
);
  import stop_watch_pkg::*;

  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  logic [3:0]    btn_pedge;
  logic [15:0]   value;
  logic          running;
  logic          lap_view;
  logic [CW-1:0] lap_count;
  logic [IW-1:0] lap_index;
  logic          overflow;
  state_t        state_dbg;

  modport master (
    output btn_pedge,
    input  value, running, lap_view, lap_count, lap_index, overflow, state_dbg
  );

  modport slave (
    input  btn_pedge,
    output value, running, lap_view, lap_count, lap_index, overflow, state_dbg
  );

endinterface

// File: rtl/stop_watch_lap_mem_bcd_time_counter.sv
// mm:ss.cc BCD time register advanced by one centisecond per tick,
// wrapping 59:59.99 -> 00:00.00 with a same-cycle wrap pulse.
module bcd_time_counter
  import stop_watch_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      clear,
  input  logic      tick,
  output bcd_time_t time_bcd,
  output logic      wrap
);

  bcd_time_t time_q;
  bcd_time_t time_d;

  assign time_bcd = time_q;
  assign wrap     = tick && (time_q == TIME_MAX);

  // Digit cascade: each digit rolls over only when all lower digits do
  always_comb begin
    time_d = time_q;
    if (time_q.csec1 != 4'd9) time_d.csec1 = time_q.csec1 + 4'd1;
    else begin
      time_d.csec1 = 4'd0;
      if (time_q.csec10 != 4'd9) time_d.csec10 = time_q.csec10 + 4'd1;
      else begin
        time_d.csec10 = 4'd0;
        if (time_q.sec1 != 4'd9) time_d.sec1 = time_q.sec1 + 4'd1;
        else begin
          time_d.sec1 = 4'd0;
          if (time_q.sec10 != 4'd5) time_d.sec10 = time_q.sec10 + 4'd1;
          else begin
            time_d.sec10 = 4'd0;
            if (time_q.min1 != 4'd9) time_d.min1 = time_q.min1 + 4'd1;
            else begin
              time_d.min1 = 4'd0;
              if (time_q.min10 != 4'd5) time_d.min10 = time_q.min10 + 4'd1;
              else time_d.min10 = 4'd0;
            end
          end
        end
      end
    end
  end

  // Time register: clear wins over tick, otherwise hold between ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   time_q <= '0;
    else if (clear) time_q <= '0;
    else if (tick)  time_q <= time_d;
  end

endmodule

// File: rtl/stop_watch_lap_mem.sv
// Stopwatch mode: centisecond divider, IDLE/RUN/STOP/RECALL control,
// circular lap memory with newest-first recall and two-window display mux.
module stop_watch_lap_mem
  import stop_watch_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int LAP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stop_watch_lap_mem_if.slave  bus
);

  localparam int DIV_N = CLK_HZ / 100;
  localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_N - 1);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  state_t          state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic            tick, wrap;
  bcd_time_t       time_cur, shown;
  logic            b_start, b_lap, b_rcl;
  logic            clear, capture, idx_zero, idx_step;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   idx_q, wr_ptr_q, rd_ptr;
  logic            view_q, ovf_q;
  int              rd_int;
  bcd_time_t       lap_mem [LAP_DEPTH];

  // Start/stop beats lap/clear beats recall within one cycle
  assign b_start = bus.btn_pedge[BTN_START];
  assign b_lap   = bus.btn_pedge[BTN_LAP] && !b_start;
  assign b_rcl   = bus.btn_pedge[BTN_RECALL] && !bus.btn_pedge[BTN_LAP] && !b_start;

  assign tick = (state_q == ST_RUN) && (div_q == DIV_MAX);

  bcd_time_counter u_time (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .tick     (tick),
    .time_bcd (time_cur),
    .wrap     (wrap)
  );

  // Divider advances only in RUN and keeps its partial count across STOP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                div_q <= '0;
    else if (clear)              div_q <= '0;
    else if (state_q == ST_RUN)  div_q <= tick ? '0 : div_q + 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and the one-cycle action strobes
  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    capture  = 1'b0;
    idx_zero = 1'b0;
    idx_step = 1'b0;
    unique case (state_q)
      ST_IDLE: if (b_start) state_d = ST_RUN;
      ST_RUN: begin
        if (b_start)    state_d = ST_STOP;
        else if (b_lap) capture = 1'b1;
      end
      ST_STOP: begin
        if (b_start) state_d = ST_RUN;
        else if (b_lap) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else if (b_rcl && (count_q != '0)) begin
          state_d  = ST_RECALL;
          idx_zero = 1'b1;
        end
      end
      ST_RECALL: begin
        if (b_start) begin
          state_d  = ST_RUN;
          idx_zero = 1'b1;
        end else if (b_lap) state_d = ST_STOP;
        else if (b_rcl)     idx_step = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lap bookkeeping, recall index, view toggle and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      view_q   <= VIEW_SEC;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.btn_pedge[BTN_VIEW]) view_q <= ~view_q;
      if (clear) begin
        count_q  <= '0;
        idx_q    <= '0;
        wr_ptr_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (wrap) ovf_q <= 1'b1;
        if (capture) begin
          wr_ptr_q <= (wr_ptr_q == IW'(LAP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
          if (count_q != CW'(LAP_DEPTH)) count_q <= count_q + 1'b1;
        end
        if (idx_zero)      idx_q <= '0;
        else if (idx_step) idx_q <= (CW'(idx_q) == count_q - 1'b1) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Lap storage; contents are hidden by count_q after reset or clear
  always_ff @(posedge clk) begin
    if (capture) lap_mem[wr_ptr_q] <= time_cur;
  end

  // Entry k lives at wr_ptr-1-k, modulo the memory depth
  always_comb begin
    rd_int = int'(wr_ptr_q) - 1 - int'(idx_q);
    if (rd_int < 0) rd_int = rd_int + LAP_DEPTH;
    rd_ptr = IW'(rd_int);
  end

  assign shown         = (state_q == ST_RECALL) ? lap_mem[rd_ptr] : time_cur;
  assign bus.value     = view_digits(shown, view_q);
  assign bus.running   = (state_q == ST_RUN);
  assign bus.lap_view  = (state_q == ST_RECALL);
  assign bus.lap_count = count_q;
  assign bus.lap_index = idx_q;
  assign bus.overflow  = ovf_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_stop_watch_lap_mem.sv
// Bench for stop_watch_lap_mem: a slow instance (csec every 10 cycles) for
// the vector table and a fast instance (csec every cycle) for the
// minute-range view and wrap sequences.
module tb_stop_watch_lap_mem;
  import stop_watch_pkg::*;

  localparam int W = 24;

  logic clk = 1'b0;
  logic reset_n;

  stop_watch_lap_mem_if #(.LAP_DEPTH(4)) slow_if ();
  stop_watch_lap_mem_if #(.LAP_DEPTH(4)) fast_if ();

  stop_watch_lap_mem #(.CLK_HZ(1000), .LAP_DEPTH(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (slow_if)
  );

  stop_watch_lap_mem #(.CLK_HZ(100), .LAP_DEPTH(4)) u_fast (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (fast_if)
  );

  typedef struct {
    logic [3:0]  btn;
    int          n;
    logic [15:0] v;
    logic        r;
    logic        lv;
    logic [2:0]  c;
    logic [1:0]  i;
    logic        o;
  } vec_t;

  vec_t vecs [49];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ex(input logic [15:0] v, input logic r, input logic lv,
                                      input logic [2:0] c, input logic [1:0] i, input logic o);
    return {v, r, lv, c, i, o};
  endfunction

  function automatic logic [W-1:0] snap(input bit fast);
    if (fast) return {fast_if.value, fast_if.running, fast_if.lap_view,
                      fast_if.lap_count, fast_if.lap_index, fast_if.overflow};
    return {slow_if.value, slow_if.running, slow_if.lap_view,
            slow_if.lap_count, slow_if.lap_index, slow_if.overflow};
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    logic [W-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got value=%h run=%b lap_view=%b count=%0d idx=%0d ovf=%b, want value=%h run=%b lap_view=%b count=%0d idx=%0d ovf=%b",
               name, act[23:8], act[7], act[6], act[5:3], act[2:1], act[0],
               e[23:8], e[7], e[6], e[5:3], e[2:1], e[0]);
    end
  endtask

  task automatic check_state(input string name, input state_t act, input state_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d want state=%0d", name, act, exp);
    end
  endtask

  // driver: one-cycle button pulse, leaves us 1 time unit after the edge
  task automatic pulse(input bit fast, input logic [3:0] b);
    if (fast) fast_if.btn_pedge = b;
    else      slow_if.btn_pedge = b;
    @(posedge clk);
    #1;
    slow_if.btn_pedge = 4'b0000;
    fast_if.btn_pedge = 4'b0000;
  endtask

  task automatic run_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // btn, wait, value, running, lap_view, lap_count, lap_index, overflow
    vecs[0]  = '{4'b0001, 999, 16'h0099, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000,   1, 16'h0100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[2]  = '{4'b0001,   0, 16'h0100, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[3]  = '{4'b0000,  30, 16'h0100, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[4]  = '{4'b0001,   8, 16'h0100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[5]  = '{4'b0000,   1, 16'h0101, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[6]  = '{4'b0000,   5, 16'h0101, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[7]  = '{4'b0001,   0, 16'h0101, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[8]  = '{4'b0001,   3, 16'h0101, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[9]  = '{4'b0000,   1, 16'h0102, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[10] = '{4'b0001,   0, 16'h0102, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[11] = '{4'b0010,   0, 16'h0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[12] = '{4'b0001, 100, 16'h0010, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[13] = '{4'b0010,  99, 16'h0020, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0};
    vecs[14] = '{4'b0010,  99, 16'h0030, 1'b1, 1'b0, 3'd2, 2'd0, 1'b0};
    vecs[15] = '{4'b0010,  99, 16'h0040, 1'b1, 1'b0, 3'd3, 2'd0, 1'b0};
    vecs[16] = '{4'b0010,  99, 16'h0050, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[17] = '{4'b0010,   0, 16'h0050, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[18] = '{4'b0001,   0, 16'h0050, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[19] = '{4'b0100,   0, 16'h0050, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0};
    vecs[20] = '{4'b0100,   0, 16'h0040, 1'b0, 1'b1, 3'd4, 2'd1, 1'b0};
    vecs[21] = '{4'b0100,   0, 16'h0030, 1'b0, 1'b1, 3'd4, 2'd2, 1'b0};
    vecs[22] = '{4'b0100,   0, 16'h0020, 1'b0, 1'b1, 3'd4, 2'd3, 1'b0};
    vecs[23] = '{4'b0100,   0, 16'h0050, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0};
    vecs[24] = '{4'b1000,   0, 16'h0000, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0};
    vecs[25] = '{4'b1000,   0, 16'h0050, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0};
    vecs[26] = '{4'b0010,   0, 16'h0050, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[27] = '{4'b0011,   0, 16'h0050, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[28] = '{4'b0011,   0, 16'h0050, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[29] = '{4'b0100,   0, 16'h0050, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0};
    vecs[30] = '{4'b0100,   0, 16'h0040, 1'b0, 1'b1, 3'd4, 2'd1, 1'b0};
    vecs[31] = '{4'b0100,   0, 16'h0030, 1'b0, 1'b1, 3'd4, 2'd2, 1'b0};
    vecs[32] = '{4'b0100,   0, 16'h0020, 1'b0, 1'b1, 3'd4, 2'd3, 1'b0};
    vecs[33] = '{4'b0001,   0, 16'h0050, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[34] = '{4'b0110,   0, 16'h0050, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[35] = '{4'b0001,   0, 16'h0050, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[36] = '{4'b0100,   0, 16'h0050, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0};
    vecs[37] = '{4'b0100,   0, 16'h0050, 1'b0, 1'b1, 3'd4, 2'd1, 1'b0};
    vecs[38] = '{4'b0100,   0, 16'h0040, 1'b0, 1'b1, 3'd4, 2'd2, 1'b0};
    vecs[39] = '{4'b0100,   0, 16'h0030, 1'b0, 1'b1, 3'd4, 2'd3, 1'b0};
    vecs[40] = '{4'b0001,   0, 16'h0050, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[41] = '{4'b0001,   0, 16'h0050, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0};
    vecs[42] = '{4'b0110,   0, 16'h0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[43] = '{4'b0100,   0, 16'h0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[44] = '{4'b0010,   0, 16'h0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[45] = '{4'b0001,   0, 16'h0000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[46] = '{4'b0001,   0, 16'h0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[47] = '{4'b0100,   0, 16'h0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[48] = '{4'b0001,  25, 16'h0002, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};

    // reset
    slow_if.btn_pedge = 4'b0000;
    fast_if.btn_pedge = 4'b0000;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_slow", snap(0), ex(16'h0000, 0, 0, 3'd0, 2'd0, 0));
    check("reset_fast", snap(1), ex(16'h0000, 0, 0, 3'd0, 2'd0, 0));
    check_state("reset_state", slow_if.state_dbg, ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", snap(0), ex(16'h0000, 0, 0, 3'd0, 2'd0, 0));

    // table on the slow instance
    for (int k = 0; k < 49; k++) begin
      if (vecs[k].btn != 4'b0000) pulse(0, vecs[k].btn);
      run_cycles(vecs[k].n);
      check($sformatf("vec%0d", k), snap(0),
            ex(vecs[k].v, vecs[k].r, vecs[k].lv, vecs[k].c, vecs[k].i, vecs[k].o));
    end
    check_state("clear_then_run_state", slow_if.state_dbg, ST_RUN);

    // fast instance: minute-range view toggles while running
    pulse(1, 4'b0001);
    run_cycles(6202);
    check("fast_01_02_02", snap(1), ex(16'h0202, 1, 0, 3'd0, 2'd0, 0));
    pulse(1, 4'b1000);
    check("fast_view_min", snap(1), ex(16'h0102, 1, 0, 3'd0, 2'd0, 0));
    pulse(1, 4'b1000);
    check("fast_view_sec", snap(1), ex(16'h0204, 1, 0, 3'd0, 2'd0, 0));
    pulse(1, 4'b0001);
    check("fast_stop", snap(1), ex(16'h0205, 0, 0, 3'd0, 2'd0, 0));

    // fast instance: preload near the top of the range, then wrap
    force u_fast.u_time.time_q = 24'h595998;
    #1;
    release u_fast.u_time.time_q;
    pulse(1, 4'b0001);
    check("wrap_pre", snap(1), ex(16'h5998, 1, 0, 3'd0, 2'd0, 0));
    run_cycles(1);
    check("wrap_max", snap(1), ex(16'h5999, 1, 0, 3'd0, 2'd0, 0));
    run_cycles(1);
    check("wrap_zero", snap(1), ex(16'h0000, 1, 0, 3'd0, 2'd0, 1));
    run_cycles(5);
    check("wrap_sticky_run", snap(1), ex(16'h0005, 1, 0, 3'd0, 2'd0, 1));
    pulse(1, 4'b0001);
    check("wrap_sticky_stop", snap(1), ex(16'h0006, 0, 0, 3'd0, 2'd0, 1));
    pulse(1, 4'b0100);
    check("recall_empty", snap(1), ex(16'h0006, 0, 0, 3'd0, 2'd0, 1));
    pulse(1, 4'b0001);
    pulse(1, 4'b0001);
    check("wrap_sticky_resume", snap(1), ex(16'h0007, 0, 0, 3'd0, 2'd0, 1));
    pulse(1, 4'b0010);
    check("wrap_cleared", snap(1), ex(16'h0000, 0, 0, 3'd0, 2'd0, 0));
    check_state("fast_idle", fast_if.state_dbg, ST_IDLE);

    // asynchronous reset while the slow instance is running
    run_cycles(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_slow", snap(0), ex(16'h0000, 0, 0, 3'd0, 2'd0, 0));
    check_state("async_reset_state", slow_if.state_dbg, ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    pulse(0, 4'b0001);
    run_cycles(9);
    check("after_reset_div9", snap(0), ex(16'h0000, 1, 0, 3'd0, 2'd0, 0));
    run_cycles(1);
    check("after_reset_div10", snap(0), ex(16'h0001, 1, 0, 3'd0, 2'd0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
